// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: widths, port ids, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 128;

  // Requester ids; also the encoding of the grant and last_grant bits.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  // The memory is word-organised; anything not on a 4-byte boundary is refused.
  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the data-memory pins.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their one-cycle ready pulse.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();

  // Port 0: CPU load/store unit
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ready0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  // Port 1: debug/DMA loader
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ready1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  // Memory side
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ready0, rdata0, err0,
    input  req1, we1, addr1, wdata1,
    output ready1, rdata1, err1,
    output MemRead, MemWrite, mem_add, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory view.
  modport master (
    output req0, we0, addr0, wdata0,
    input  ready0, rdata0, err0,
    output req1, we1, addr1, wdata1,
    input  ready1, rdata1, err1,
    input  MemRead, MemWrite, mem_add, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the port that did not win last time wins.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Single requester wins outright; a tie goes to the port opposite last_grant.
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 128x32 data memory between the CPU (port 0) and debug/DMA (port 1).
// Latency: req sampled in IDLE cycle N, memory access N+1, ready pulse N+2.
// Backpressure: one access in flight; a waiting port holds req until its ready.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  dmem_state_e state;

  // Transaction latched at grant time; requester inputs are ignored after that.
  // The latched address and write data live directly in mem_add / mem_wdata.
  logic lat_id;
  logic lat_we;
  logic lat_mis;
  logic last_grant;

  logic grant_valid;
  logic grant_id;

  // Fields of whichever port the picker selects this cycle.
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mis;

  rr_arb2 u_rr_arb2 (
    .req         ({bus.req1, bus.req0}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Steer the granted port's request fields toward the latches.
  always_comb begin
    sel_we    = grant_id ? bus.we1    : bus.we0;
    sel_addr  = grant_id ? bus.addr1  : bus.addr0;
    sel_wdata = grant_id ? bus.wdata1 : bus.wdata0;
    sel_mis   = is_misaligned(sel_addr[1:0]);
  end

  // Control FSM; every output, including the memory strobes, comes from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= PORT_DBG;
      lat_id        <= PORT_CPU;
      lat_we        <= 1'b0;
      lat_mis       <= 1'b0;
      bus.ready0    <= 1'b0;
      bus.ready1    <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= 1'b0;
      bus.mem_add   <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // Strobes and response flags are single-cycle unless set below.
      bus.ready0   <= 1'b0;
      bus.ready1   <= 1'b0;
      bus.err0     <= 1'b0;
      bus.err1     <= 1'b0;
      bus.MemRead  <= 1'b0;
      bus.MemWrite <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            lat_id        <= grant_id;
            lat_we        <= sel_we;
            lat_mis       <= sel_mis;
            last_grant    <= grant_id;
            bus.mem_add   <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            // Strobes are set here so they are high during exactly the ACCESS cycle;
            // a misaligned access never touches the memory.
            bus.MemRead   <= !sel_we && !sel_mis;
            bus.MemWrite  <= sel_we && !sel_mis;
            state         <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // Memory read data is combinational, so it is valid by the end of ACCESS.
          if (!lat_we && !lat_mis) begin
            if (lat_id == PORT_DBG) bus.rdata1 <= bus.mem_rdata;
            else                    bus.rdata0 <= bus.mem_rdata;
          end
          if (lat_id == PORT_DBG) begin
            bus.ready1 <= 1'b1;
            bus.err1   <= lat_mis;
          end else begin
            bus.ready0 <= 1'b1;
            bus.err0   <= lat_mis;
          end
          state <= ST_RESP;
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a transaction-level model.
// Latency: checks ACCESS strobes at N+1 and the ready pulse at N+2.
// Backpressure: requests are held until their predicted ready cycle.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Known power-on contents so reads have predictable values.
  function automatic logic [31:0] init_word(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Memory attached to the arbiter: level write sampled on the clock, combinational read.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
    end else if (bus.MemWrite) begin
      mem[bus.mem_add[8:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_add[8:2]];

  // Reference model: memory image, per-port read-data, tie-break history, pending requests.
  logic [31:0] ref_mem [0:127];
  logic [31:0] exp_rdata [0:1];
  int          exp_last;
  bit          pend  [0:1];
  bit          p_we  [0:1];
  logic [8:0]  p_addr [0:1];
  logic [31:0] p_wdata [0:1];

  int vectors;
  int miscompares;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_last     = 1;
    pend[0]      = 1'b0;
    pend[1]      = 1'b0;
  endtask

  task automatic drive(input int p);
    if (p == 0) begin
      bus.req0 = pend[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wdata[0];
    end else begin
      bus.req1 = pend[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wdata[1];
    end
  endtask

  task automatic new_req(input int p, input bit we, input logic [8:0] a, input logic [31:0] d);
    pend[p]    = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = a;
    p_wdata[p] = d;
    drive(p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1 ({tag, "_ready0"},   bus.ready0,   1'b0);
    check1 ({tag, "_ready1"},   bus.ready1,   1'b0);
    check1 ({tag, "_err0"},     bus.err0,     1'b0);
    check1 ({tag, "_err1"},     bus.err1,     1'b0);
    check32({tag, "_rdata0"},   bus.rdata0,   32'h0);
    check32({tag, "_rdata1"},   bus.rdata1,   32'h0);
    check1 ({tag, "_memread"},  bus.MemRead,  1'b0);
    check1 ({tag, "_memwrite"}, bus.MemWrite, 1'b0);
    check32({tag, "_mem_add"},  32'(bus.mem_add), 32'h0);
    check32({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // Called at a negedge while the arbiter is idle; runs one full transaction (or one idle cycle).
  task automatic serve(input bit drop);
    int g;
    bit mis;
    if (!pend[0] && !pend[1]) begin
      tick();
      check1("quiet_ready0", bus.ready0, 1'b0);
      check1("quiet_ready1", bus.ready1, 1'b0);
      check1("quiet_memwrite", bus.MemWrite, 1'b0);
      return;
    end
    if (pend[0] && pend[1]) g = 1 - exp_last;
    else                    g = pend[1] ? 1 : 0;
    mis = (p_addr[g][1:0] != 2'b00);

    tick();  // ACCESS cycle
    check1 ("acc_memread",  bus.MemRead,  !p_we[g] && !mis);
    check1 ("acc_memwrite", bus.MemWrite, p_we[g] && !mis);
    check32("acc_mem_add",  32'(bus.mem_add), 32'(p_addr[g]));
    check32("acc_mem_wdata", bus.mem_wdata, p_wdata[g]);
    check1 ("acc_ready0", bus.ready0, 1'b0);
    check1 ("acc_ready1", bus.ready1, 1'b0);
    // Granted port's inputs no longer matter: scramble them, optionally drop req.
    if (g == 0) begin
      bus.addr0 = 9'($urandom); bus.wdata0 = $urandom; bus.we0 = 1'($urandom);
      if (drop) bus.req0 = 1'b0;
    end else begin
      bus.addr1 = 9'($urandom); bus.wdata1 = $urandom; bus.we1 = 1'($urandom);
      if (drop) bus.req1 = 1'b0;
    end
    if (!mis && !p_we[g]) exp_rdata[g] = ref_mem[p_addr[g][8:2]];
    if (!mis && p_we[g])  ref_mem[p_addr[g][8:2]] = p_wdata[g];

    tick();  // RESP cycle
    check1 ("resp_ready0", bus.ready0, g == 0);
    check1 ("resp_ready1", bus.ready1, g == 1);
    check1 ("resp_err0",   bus.err0,   (g == 0) && mis);
    check1 ("resp_err1",   bus.err1,   (g == 1) && mis);
    check32("resp_rdata0", bus.rdata0, exp_rdata[0]);
    check32("resp_rdata1", bus.rdata1, exp_rdata[1]);
    check1 ("resp_memwrite", bus.MemWrite, 1'b0);
    check1 ("resp_memread",  bus.MemRead,  1'b0);
    pend[g]  = 1'b0;
    drive(g);
    exp_last = g;

    tick();  // back in IDLE: pulses must be over
    check1("post_ready0", bus.ready0, 1'b0);
    check1("post_ready1", bus.ready1, 1'b0);
    check1("post_err0",   bus.err0,   1'b0);
    check1("post_err1",   bus.err1,   1'b0);
    check1("post_memwrite", bus.MemWrite, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    p_we[0] = 1'b0; p_addr[0] = '0; p_wdata[0] = '0;
    p_we[1] = 1'b0; p_addr[1] = '0; p_wdata[1] = '0;
    model_reset();
    drive(0);
    drive(1);
    repeat (3) tick();
    check_reset_outputs("reset");

    // Both ports read in the first cycle out of reset: port 0 first, port 1 three cycles later.
    reset = 1'b0;
    new_req(0, 1'b0, 9'h020, 32'h1111_1111);
    new_req(1, 1'b0, 9'h040, 32'h2222_2222);
    serve(1'b0);
    serve(1'b0);

    // Port 0 write then read-back of the same word.
    new_req(0, 1'b1, 9'h010, 32'hDEAD_BEEF);
    serve(1'b0);
    new_req(0, 1'b0, 9'h010, 32'h0);
    serve(1'b0);
    check32("readback_0x010", bus.rdata0, 32'hDEAD_BEEF);

    // Both ports requesting continuously for six transactions (away from word 4).
    for (int n = 0; n < 6; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) new_req(p, 1'($urandom), {7'($urandom_range(8, 127)), 2'b00}, $urandom);
      serve(1'b0);
    end
    while (pend[0] || pend[1]) serve(1'b0);

    // Misaligned write from port 1 must not disturb word 4.
    new_req(1, 1'b1, 9'h013, 32'h1234_5678);
    serve(1'b0);
    new_req(1, 1'b0, 9'h010, 32'h0);
    serve(1'b0);
    check32("word4_unchanged", bus.rdata1, 32'hDEAD_BEEF);

    // Port 1 read with req dropped during ACCESS still completes.
    new_req(1, 1'b0, 9'h020, 32'h0);
    serve(1'b1);

    // Reset during the ACCESS cycle of a port 0 write: no ready, everything back to reset values.
    new_req(0, 1'b1, 9'h0F0, 32'hCAFE_F00D);
    tick();
    check1("abort_acc_memwrite", bus.MemWrite, 1'b1);
    reset    = 1'b1;
    pend[0]  = 1'b0;
    drive(0);
    tick();
    check_reset_outputs("abort");
    reset = 1'b0;
    model_reset();
    tick();
    check1("abort_no_ready0", bus.ready0, 1'b0);
    new_req(0, 1'b0, 9'h0F0, 32'h0);
    serve(1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 9) < 6)) begin
          bit         we;
          logic [8:0] a;
          we = 1'($urandom);
          a  = {7'($urandom), 2'b00};
          if (we && ($urandom_range(0, 4) == 0)) a[1:0] = 2'($urandom_range(1, 3));
          new_req(p, we, a, $urandom);
        end
      end
      serve($urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
